// File: rtl/instr_fetch_if.sv
// Bundle of fetch-unit handshakes: imem request/response, redirect, and the decode-facing output.
// MISALIGN_EXC_EN adds the out_misalign flag alongside the output word.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef MISALIGN_EXC_EN
    logic        out_misalign;
`endif

    modport master (
`ifdef MISALIGN_EXC_EN
        output out_misalign,
`endif
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
`ifdef MISALIGN_EXC_EN
        input  out_misalign,
`endif
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC owner, credit-limited imem requests, DEPTH-entry output FIFO, redirect squash.
// Optional MISALIGN_EXC_EN: misaligned redirect halts fetch and emits one flagged nop entry.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CRW = CW + 2;

    typedef enum logic {RUN, HALT} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]          inflight_q, inflight_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d, prd_q, prd_d, pwr_q, pwr_d;
    logic [DEPTH-1:0][31:0] f_pc_q, f_pc_d, f_instr_q, f_instr_d, pcq_q, pcq_d;
`ifdef MISALIGN_EXC_EN
    logic [DEPTH-1:0]       f_mis_q, f_mis_d;
    logic                   pend_q, pend_d;
    logic [31:0]            halt_pc_q, halt_pc_d;
    logic                   push_mis;
`endif
    logic [CRW-1:0]         used;
    logic                   req_hs, rsp, pop, push;
    logic [31:0]            push_pc, push_instr;

    // Every slot already in flight, squashed, or buffered consumes one FIFO credit.
    assign used   = CRW'(inflight_q) + CRW'(drop_q) + CRW'(cnt_q);
    assign bus.imem_req_valid = !rst && (state_q == RUN) && (used < CRW'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = (cnt_q != '0);
    assign bus.out_pc         = f_pc_q[rd_q];
    assign bus.out_instr      = f_instr_q[rd_q];
`ifdef MISALIGN_EXC_EN
    assign bus.out_misalign   = f_mis_q[rd_q];
`endif

    assign req_hs = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp    = bus.imem_rsp_valid;
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        prd_d      = prd_q;
        pwr_d      = pwr_q;
        f_pc_d     = f_pc_q;
        f_instr_d  = f_instr_q;
        pcq_d      = pcq_q;
        push       = 1'b0;
        push_pc    = pcq_q[prd_q];
        push_instr = bus.imem_rsp_data;
`ifdef MISALIGN_EXC_EN
        f_mis_d    = f_mis_q;
        pend_d     = pend_q;
        halt_pc_d  = halt_pc_q;
        push_mis   = 1'b0;
`endif
        if (bus.redirect_valid) begin
            // Everything outstanding, including this cycle's request, becomes a squash credit.
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            drop_d     = drop_q + inflight_q + CW'(req_hs) - CW'(rsp);
            inflight_d = '0;
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            prd_d      = '0;
            pwr_d      = '0;
`ifdef MISALIGN_EXC_EN
            halt_pc_d  = bus.redirect_pc;
            pend_d     = |bus.redirect_pc[1:0];
            state_d    = (|bus.redirect_pc[1:0]) ? HALT : RUN;
`endif
        end else begin
            inflight_d = inflight_q + CW'(req_hs) - CW'(rsp && (drop_q == '0));
            if (req_hs) begin
                fetch_pc_d   = fetch_pc_q + 32'd4;
                pcq_d[pwr_q] = fetch_pc_q;
                pwr_d        = pwr_q + AW'(1);
            end
            if (rsp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push  = 1'b1;
                    prd_d = prd_q + AW'(1);
                end
            end
`ifdef MISALIGN_EXC_EN
            // No requests issue in HALT, so once squashes drain the FIFO is empty.
            if (state_q == HALT && pend_q && drop_q == '0) begin
                push       = 1'b1;
                push_pc    = halt_pc_q;
                push_instr = 32'h0000_0013;
                push_mis   = 1'b1;
                pend_d     = 1'b0;
            end
`endif
            if (push) begin
                f_pc_d[wr_q]    = push_pc;
                f_instr_d[wr_q] = push_instr;
`ifdef MISALIGN_EXC_EN
                f_mis_d[wr_q]   = push_mis;
`endif
                wr_d            = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            prd_q      <= '0;
            pwr_q      <= '0;
            f_pc_q     <= '0;
            f_instr_q  <= '0;
            pcq_q      <= '0;
`ifdef MISALIGN_EXC_EN
            f_mis_q    <= '0;
            pend_q     <= 1'b0;
            halt_pc_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            prd_q      <= prd_d;
            pwr_q      <= pwr_d;
            f_pc_q     <= f_pc_d;
            f_instr_q  <= f_instr_d;
            pcq_q      <= pcq_d;
`ifdef MISALIGN_EXC_EN
            f_mis_q    <= f_mis_d;
            pend_q     <= pend_d;
            halt_pc_q  <= halt_pc_d;
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a queue-based fetch model
// that owns the instruction memory and tracks every outstanding request as live or squashed.
module tb_instr_fetch;
    localparam int DEPTH = 2;

    typedef struct {logic [31:0] addr; int due; bit live;} mreq_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr; bit mis;} ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus();
    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    mreq_t       memq[$];
    ent_t        fq[$];
    logic [31:0] hs_log[$];
    logic [31:0] m_pc, m_hpc, k_tgt, obs_pc, obs_instr;
    bit          m_run, m_pend, prev_rst, obs_ov, obs_mis;
    bit          k_rst, k_rdy, k_ordy, k_redir, k_auto, auto_hit;
    int          now, lat, last_due, checks, failures;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete(); fq.delete();
        m_pc = 32'h0; m_run = 1'b1; m_pend = 1'b0; last_due = 0;
    endtask

    // One clock: drive inputs at negedge, compare at negedge+1, then advance the model.
    task automatic tick();
        bit ev_rsp, ev_hs, ev_pop, exp_rv, redir;
        int inq, due;
        mreq_t h;
        @(negedge clk);
        rst    = k_rst;
        inq    = memq.size();
        ev_rsp = !k_rst && inq > 0 && memq[0].due <= now;
        exp_rv = !k_rst && m_run && (inq + fq.size() < DEPTH);
        redir  = !k_rst && (k_redir || (k_auto && ev_rsp && exp_rv && k_rdy));
        if (k_auto && redir) begin auto_hit = 1'b1; k_auto = 1'b0; end
        bus.imem_rsp_valid = ev_rsp;
        bus.imem_rsp_data  = ev_rsp ? memf(memq[0].addr) : $urandom;
        bus.imem_req_ready = k_rdy;
        bus.out_ready      = k_ordy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = k_tgt;
        #1;
        obs_ov = bus.out_valid; obs_pc = bus.out_pc; obs_instr = bus.out_instr;
`ifdef MISALIGN_EXC_EN
        obs_mis = bus.out_misalign;
`else
        obs_mis = 1'b0;
`endif
        if (bus.imem_req_valid && k_rdy) hs_log.push_back(bus.imem_req_addr);
        if (k_rst) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            if (prev_rst) begin
                chk("rst_out_valid", 32'(obs_ov), 32'd0);
                chk("rst_out_pc", obs_pc, 32'd0);
                chk("rst_out_instr", obs_instr, 32'd0);
                chk("rst_out_mis", 32'(obs_mis), 32'd0);
            end
            prev_rst = 1'b1;
            model_reset();
            now++;
            @(posedge clk);
            return;
        end
        prev_rst = 1'b0;
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("out_valid", 32'(obs_ov), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("out_pc", obs_pc, fq[0].pc);
            chk("out_instr", obs_instr, fq[0].instr);
`ifdef MISALIGN_EXC_EN
            chk("out_mis", 32'(obs_mis), 32'(fq[0].mis));
`endif
        end
        ev_hs  = exp_rv && k_rdy;
        ev_pop = fq.size() != 0 && k_ordy;
        due = now + lat;
        if (due <= last_due) due = last_due + 1;
        if (ev_rsp) h = memq.pop_front();
        if (redir) begin
            fq.delete();
            foreach (memq[i]) memq[i].live = 1'b0;
            if (ev_hs) begin memq.push_back('{m_pc, due, 1'b0}); last_due = due; end
            m_pc = k_tgt & 32'hFFFF_FFFC;
`ifdef MISALIGN_EXC_EN
            m_run = (k_tgt[1:0] == 2'b00); m_pend = !m_run; m_hpc = k_tgt;
`endif
        end else begin
            if (ev_pop) void'(fq.pop_front());
            if (ev_rsp && h.live) fq.push_back('{h.addr, memf(h.addr), 1'b0});
            if (!m_run && m_pend && inq == 0) begin
                fq.push_back('{m_hpc, 32'h0000_0013, 1'b1});
                m_pend = 1'b0;
            end
            if (ev_hs) begin
                memq.push_back('{m_pc, due, 1'b1}); last_due = due;
                m_pc = m_pc + 32'd4;
            end
        end
        now++;
        @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        k_rst = 1'b1; k_redir = 1'b0;
        repeat (n) tick();
        k_rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        k_tgt = t; k_redir = 1'b1; tick(); k_redir = 1'b0;
    endtask

    // Bounded wait for the next visible output word.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!obs_ov && n < 30) begin tick(); n++; end
        chk(tag, 32'(obs_ov), 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0; now = 0; lat = 1; prev_rst = 1'b1;
        k_rst = 1'b1; k_rdy = 1'b1; k_ordy = 1'b1; k_redir = 1'b0; k_auto = 1'b0; k_tgt = '0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset(3);

        // Stalled decode: only DEPTH requests go out and the head holds pc 0.
        hs_log.delete(); k_ordy = 1'b0;
        repeat (10) tick();
        chk("t2_req_count", 32'(hs_log.size()), 32'(DEPTH));
        chk("t2_head_pc", obs_pc, 32'h0);
        k_ordy = 1'b1;
        repeat (12) tick();

        // Free-running from reset with 1-cycle memory.
        do_reset(2);
        hs_log.delete();
        repeat (20) tick();
        if (hs_log.size() >= 3) begin
            chk("t1_addr0", hs_log[0], 32'h0);
            chk("t1_addr1", hs_log[1], 32'h4);
            chk("t1_addr2", hs_log[2], 32'h8);
        end else chk("t1_req_count", 32'(hs_log.size()), 32'd3);

        // Redirect with two requests outstanding at latency 3.
        lat = 3;
        for (int i = 0; i < 30 && memq.size() != 2; i++) tick();
        chk("t3_two_inflight", 32'(memq.size()), 32'd2);
        redirect_to(32'h0000_0100);
        wait_out("t3_out_seen");
        chk("t3_first_pc", obs_pc, 32'h0000_0100);
        repeat (10) tick();

        // Redirect coinciding with both a response and a request handshake.
        lat = 1; auto_hit = 1'b0; k_auto = 1'b1; k_tgt = 32'h0000_0240;
        for (int i = 0; i < 40 && !auto_hit; i++) tick();
        k_auto = 1'b0;
        chk("t4_hit", 32'(auto_hit), 32'd1);
        wait_out("t4_out_seen");
        chk("t4_first_pc", obs_pc, 32'h0000_0240);

        // Address wraps at the top of the address space.
        redirect_to(32'hFFFF_FFF8);
        hs_log.delete();
        repeat (8) tick();
        if (hs_log.size() >= 3) chk("t5_wrap_addr", hs_log[2], 32'h0);
        else chk("t5_req_count", 32'(hs_log.size()), 32'd3);

`ifdef MISALIGN_EXC_EN
        lat = 2;
        redirect_to(32'h0000_0102);
        wait_out("t6_out_seen");
        chk("t6_pc", obs_pc, 32'h0000_0102);
        chk("t6_instr", obs_instr, 32'h0000_0013);
        chk("t6_mis", 32'(obs_mis), 32'd1);
        hs_log.delete();
        repeat (10) tick();
        chk("t6_no_reqs", 32'(hs_log.size()), 32'd0);
        redirect_to(32'h0000_0200);
        wait_out("t6_resume");
        chk("t6_resume_pc", obs_pc, 32'h0000_0200);
`endif

        // Random traffic, a mid-run reset, then more random traffic.
        for (int i = 0; i < 600; i++) begin
            if (i == 350) do_reset(2);
            lat     = $urandom_range(1, 4);
            k_rdy   = ($urandom_range(0, 3) != 0);
            k_ordy  = ($urandom_range(0, 3) != 0);
            k_redir = ($urandom_range(0, 19) == 0);
            k_tgt   = $urandom;
            tick();
        end
        k_redir = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
